// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the note sequencer.
//   note_cmd_t  : one queued command, {duration in ms, frequency in Hz}
//   seq_state_t : playback FSM states
//   ADDR_*      : Avalon-MM word addresses
//   RESET_FREQ  : tone frequency presented while nothing has played yet
package note_pkg;

  typedef struct packed {
    logic [15:0] dur_ms;
    logic [15:0] freq_hz;
  } note_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } seq_state_t;

  localparam logic [1:0]  ADDR_CMD   = 2'd0;
  localparam logic [1:0]  ADDR_CTRL  = 2'd1;
  localparam logic [31:0] RESET_FREQ = 32'd1000;

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: Avalon-MM slave bus of the note sequencer.
//   avs_address   : 0 = CMD (W) / STATUS (R), 1 = CTRL (W)
//   avs_write     : single-cycle write strobe
//   avs_writedata : CMD {dur_ms, freq_hz} or CTRL {.., abort}
//   avs_read      : read strobe
//   avs_readdata  : STATUS, zero read latency
// master = CPU side, slave = sequencer side.
interface note_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO of note commands.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : enqueue din (ignored while full)
//   pop, dout    : dequeue; dout holds the popped entry from the next cycle on
//   flush        : empty the FIFO, overrides push and pop
//   full, empty, count : occupancy
module note_fifo
  import note_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  note_cmd_t                din,
  output note_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  note_cmd_t       mem [DEPTH];
  note_cmd_t       head_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = head_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
    if (do_pop)  head_q <= mem[rd_ptr_q];
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays queued note commands back to back for the tone
// generator, timing each one in milliseconds.
//   clk, reset_n : clock, asynchronous active-low reset
//   avs          : Avalon-MM slave (CMD push, CTRL abort, STATUS read)
//   tone_freq    : frequency for the tone generator
//   tone_write   : one-cycle strobe when tone_freq takes a new note
//   mute         : 1 gates the speaker off (idle or rest)
//   busy         : 1 while a note/rest is being loaded or timed
module note_sequencer
  import note_pkg::*;
#(
  parameter int FCLK  = 50_000_000,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  note_sequencer_if.slave   avs,
  output logic [31:0]       tone_freq,
  output logic              tone_write,
  output logic              mute,
  output logic              busy
);
  localparam int TICK_CYC = FCLK / 1000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

  seq_state_t      state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     ms_q, ms_d;
  logic [31:0]     tone_freq_q, tone_freq_d;
  logic            tone_write_q, tone_write_d;
  logic            mute_q, mute_d;
  logic            ovf_q, ovf_d;

  logic            cmd_push, abort, tick, last_tick;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  note_cmd_t       fifo_head;

  assign cmd_push  = avs.avs_write && (avs.avs_address == ADDR_CMD);
  assign abort     = avs.avs_write && (avs.avs_address == ADDR_CTRL) && avs.avs_writedata[0];
  assign tick      = (state_q == PLAY) && (presc_q == PRESC_LAST);
  assign last_tick = tick && (ms_q == 16'd1);

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_push),
    .pop     (fifo_pop),
    .flush   (abort),
    .din     (note_cmd_t'(avs.avs_writedata)),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tone_freq  = tone_freq_q;
  assign tone_write = tone_write_q;
  assign mute       = mute_q;
  assign busy       = (state_q != IDLE);

  assign avs.avs_readdata = (avs.avs_read && avs.avs_address == ADDR_CMD)
                          ? {20'b0, 8'(fifo_count), ovf_q, busy, fifo_full, fifo_empty}
                          : 32'd0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      ms_q         <= '0;
      tone_freq_q  <= RESET_FREQ;
      tone_write_q <= 1'b0;
      mute_q       <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      ms_q         <= ms_d;
      tone_freq_q  <= tone_freq_d;
      tone_write_q <= tone_write_d;
      mute_q       <= mute_d;
      ovf_q        <= ovf_d;
    end
  end

  // Next state and FIFO pop
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = PLAY;
      PLAY: begin
        if (last_tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      fifo_pop = 1'b0;
    end
  end

  // Outputs and timing datapath
  always_comb begin
    presc_d      = presc_q;
    ms_d         = ms_q;
    tone_freq_d  = tone_freq_q;
    tone_write_d = 1'b0;
    mute_d       = mute_q;
    ovf_d        = ovf_q;

    if (cmd_push && fifo_full) ovf_d = 1'b1;

    // The prescaler is cleared on every pop and keeps running through LOAD,
    // so the LOAD cycle is the first cycle of the first millisecond and
    // LOAD-to-LOAD spacing is exactly dur * TICK_CYC cycles.
    if (state_q != IDLE) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    if (fifo_pop) presc_d = '0;

    case (state_q)
      LOAD: begin
        ms_d = (fifo_head.dur_ms == 16'd0) ? 16'd1 : fifo_head.dur_ms;
        if (fifo_head.freq_hz != 16'd0) begin
          tone_freq_d  = {16'b0, fifo_head.freq_hz};
          tone_write_d = 1'b1;
          mute_d       = 1'b0;
        end else begin
          mute_d = 1'b1;     // rest: silence instead of a 0 Hz write
        end
      end
      PLAY: begin
        if (tick) ms_d = ms_q - 16'd1;
        if (last_tick && fifo_empty) mute_d = 1'b1;
      end
      default: ;
    endcase

    if (abort) begin
      presc_d      = '0;
      tone_freq_d  = tone_freq_q;
      tone_write_d = 1'b0;
      mute_d       = 1'b1;
      ovf_d        = 1'b0;
    end
  end
endmodule
